// File: rtl/vga_plot_pkg.sv
// Shared definitions for the VGA plot arbiter family.
// Holds the default screen geometry, the adapter field widths, the pixel
// record type and a 16-bit saturating increment used by the event counters.
package vga_plot_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;
  localparam int COLOUR_W     = 3;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin one-hot picker.
// Searches req starting at (ptr+1) mod N upward with wrap-around and grants
// the first requester found; no request gives an all-zero grant.
// Ports:
//   req  in  N      request vector
//   ptr  in  PTR_W  index of the most recently served requester
//   gnt  out N      one-hot grant (zero when req is zero)
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter pixel-write port between NREQ drawing engines.
// One requester is granted per cycle, round-robin, unless a locked burst
// owner is still requesting. The winning pixel is registered onto the
// adapter port with one cycle of latency.
// Optional build macro: PLOT_CLIP_EN -- drops off-screen pixels (still
// consumed) and counts them on clip_count.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req, req_lock        per-requester pixel valid / keep-port request
//   req_x, req_y,
//   req_colour           packed per-requester pixel fields
//   gnt                  combinational one-hot grant
//   count_clr            synchronous clear of the counters
//   vga_x, vga_y,
//   vga_colour, vga_plot registered adapter write port
//   busy                 lock held or any request pending
//   plot_count           saturating count of vga_plot pulses
//   clip_count           saturating count of clipped pixels (PLOT_CLIP_EN)
module vga_plot_arbiter
  import vga_plot_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*X_W-1:0]      req_x,
  input  logic [NREQ*Y_W-1:0]      req_y,
  input  logic [NREQ*COLOUR_W-1:0] req_colour,
  output logic [NREQ-1:0]          gnt,
  input  logic                     count_clr,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COLOUR_W-1:0]      vga_colour,
  output logic                     vga_plot,
`ifdef PLOT_CLIP_EN
  output logic [15:0]              clip_count,
`endif
  output logic                     busy,
  output logic [15:0]              plot_count
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] lock_owner_q, lock_owner_d;
  logic             lock_valid_q, lock_valid_d;
  pixel_t           px_q, px_d;
  logic             plot_q, plot_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [NREQ-1:0]  rr_gnt;
  logic [NREQ-1:0]  gnt_int;
  logic [PTR_W-1:0] win;
  pixel_t           win_px;
  logic             accept;

  rr_pick #(.N(NREQ), .PTR_W(PTR_W)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (rr_gnt)
  );

  // A live lock overrides round-robin only while its owner still requests;
  // otherwise the normal search runs and may hand the port to someone else.
  always_comb begin
    gnt_int = rr_gnt;
    if (lock_valid_q && req[lock_owner_q]) begin
      gnt_int               = '0;
      gnt_int[lock_owner_q] = 1'b1;
    end
  end

  assign accept = |gnt_int;
  assign gnt    = rst_n ? gnt_int : '0;

  // Encode the winner and pull its pixel fields out of the packed buses.
  always_comb begin
    win    = '0;
    win_px = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_int[i]) begin
        win           = PTR_W'(i);
        win_px.x      = req_x[X_W*i +: X_W];
        win_px.y      = req_y[Y_W*i +: Y_W];
        win_px.colour = req_colour[COLOUR_W*i +: COLOUR_W];
      end
    end
  end

`ifdef PLOT_CLIP_EN
  logic        in_range;
  logic        clip_inc;
  logic [15:0] clip_q, clip_d;

  assign in_range = (int'(win_px.x) < SCREEN_W) && (int'(win_px.y) < SCREEN_H);
`endif

  always_comb begin
    ptr_d        = ptr_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    px_d         = px_q;
    plot_d       = 1'b0;
`ifdef PLOT_CLIP_EN
    clip_inc     = 1'b0;
`endif
    if (accept) begin
      ptr_d = win;
      if (req_lock[win]) begin
        lock_valid_d = 1'b1;
        lock_owner_d = win;
      end else begin
        lock_valid_d = 1'b0;
      end
`ifdef PLOT_CLIP_EN
      // Off-screen pixels are consumed but never reach the adapter.
      if (in_range) begin
        px_d   = win_px;
        plot_d = 1'b1;
      end else begin
        clip_inc = 1'b1;
      end
`else
      px_d   = win_px;
      plot_d = 1'b1;
`endif
    end
  end

  // Clear wins over a simultaneous increment.
  always_comb begin
    if (count_clr)   cnt_d = '0;
    else if (plot_q) cnt_d = sat_inc16(cnt_q);
    else             cnt_d = cnt_q;
  end

`ifdef PLOT_CLIP_EN
  always_comb begin
    if (count_clr)     clip_d = '0;
    else if (clip_inc) clip_d = sat_inc16(clip_q);
    else               clip_d = clip_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clip_q <= '0;
    else        clip_q <= clip_d;
  end

  assign clip_count = clip_q;
`endif

  // Reset pointer to NREQ-1 so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= PTR_W'(NREQ - 1);
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
      px_q         <= '0;
      plot_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      ptr_q        <= ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      px_q         <= px_d;
      plot_q       <= plot_d;
      cnt_q        <= cnt_d;
    end
  end

  assign vga_x      = px_q.x;
  assign vga_y      = px_q.y;
  assign vga_colour = px_q.colour;
  assign vga_plot   = plot_q;
  assign plot_count = cnt_q;
  assign busy       = lock_valid_q | (|req);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter (NREQ=3, 160x120).
// A behavioural model of the arbitration rules runs alongside the DUT and a
// compare process checks every output on each falling edge; directed
// sections add literal expectations for the key scenarios.
module tb_vga_plot_arbiter;

  localparam int NREQ = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req, req_lock;
  logic [NREQ*8-1:0] req_x;
  logic [NREQ*7-1:0] req_y;
  logic [NREQ*3-1:0] req_colour;
  logic [NREQ-1:0] gnt;
  logic            count_clr;
  logic [7:0]      vga_x;
  logic [6:0]      vga_y;
  logic [2:0]      vga_colour;
  logic            vga_plot;
  logic            busy;
  logic [15:0]     plot_count;
`ifdef PLOT_CLIP_EN
  logic [15:0]     clip_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  vga_plot_arbiter #(.NREQ(NREQ), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_lock   (req_lock),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .gnt        (gnt),
    .count_clr  (count_clr),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
`ifdef PLOT_CLIP_EN
    .clip_count (clip_count),
`endif
    .busy       (busy),
    .plot_count (plot_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr;
  logic        m_lv;
  int          m_lo;
  logic [7:0]  m_x;
  logic [6:0]  m_y;
  logic [2:0]  m_c;
  logic        m_plot;
  logic [15:0] m_cnt;
  logic [15:0] m_clip;

  function automatic logic [NREQ-1:0] exp_gnt();
    logic [NREQ-1:0] g;
    g = '0;
    if (!rst_n) return g;
    if (m_lv && req[m_lo]) begin
      g[m_lo] = 1'b1;
      return g;
    end
    for (int k = 1; k <= NREQ; k++) begin
      if (req[(m_ptr + k) % NREQ]) begin
        g[(m_ptr + k) % NREQ] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    logic [NREQ-1:0] g;
    int              w;
    logic [7:0]      wx;
    logic [6:0]      wy;
    logic [2:0]      wc;
    logic            clipped;
    if (!rst_n) begin
      m_ptr  <= NREQ - 1;
      m_lv   <= 1'b0;
      m_lo   <= 0;
      m_x    <= '0;
      m_y    <= '0;
      m_c    <= '0;
      m_plot <= 1'b0;
      m_cnt  <= '0;
      m_clip <= '0;
    end else begin
      g = exp_gnt();
      w = -1;
      for (int i = 0; i < NREQ; i++) if (g[i]) w = i;
      clipped = 1'b0;
      if (count_clr) m_cnt <= '0;
      else if (m_plot && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      if (w >= 0) begin
        m_ptr <= w;
        if (req_lock[w]) begin
          m_lv <= 1'b1;
          m_lo <= w;
        end else begin
          m_lv <= 1'b0;
        end
        wx = req_x[8*w +: 8];
        wy = req_y[7*w +: 7];
        wc = req_colour[3*w +: 3];
`ifdef PLOT_CLIP_EN
        if (wx >= 8'd160 || wy >= 7'd120) clipped = 1'b1;
`endif
        if (clipped) begin
          m_plot <= 1'b0;
        end else begin
          m_x    <= wx;
          m_y    <= wy;
          m_c    <= wc;
          m_plot <= 1'b1;
        end
      end else begin
        m_plot <= 1'b0;
      end
      if (count_clr) m_clip <= '0;
      else if (clipped && m_clip != 16'hFFFF) m_clip <= m_clip + 16'd1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("gnt",        32'(gnt),        32'(exp_gnt()));
    chk("vga_x",      32'(vga_x),      32'(m_x));
    chk("vga_y",      32'(vga_y),      32'(m_y));
    chk("vga_colour", 32'(vga_colour), 32'(m_c));
    chk("vga_plot",   32'(vga_plot),   32'(m_plot));
    chk("busy",       32'(busy),       32'(m_lv | (|req)));
    chk("plot_count", 32'(plot_count), 32'(m_cnt));
`ifdef PLOT_CLIP_EN
    chk("clip_count", 32'(clip_count), 32'(m_clip));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    req_x[8*i +: 8]      = x;
    req_y[7*i +: 7]      = y;
    req_colour[3*i +: 3] = c;
  endtask

  logic [2:0] rr_seq [6];

  initial begin
    rst_n = 1'b0; req = '0; req_lock = '0; req_x = '0; req_y = '0;
    req_colour = '0; count_clr = 1'b0;
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
    rr_seq[3] = 3'b001; rr_seq[4] = 3'b010; rr_seq[5] = 3'b100;

    // Reset and idle
    repeat (5) begin
      @(negedge clk);
      chk("rst_plot", 32'(vga_plot), 32'd0);
      chk("rst_gnt",  32'(gnt),      32'd0);
      @(posedge clk);
    end
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_x",     32'(vga_x),      32'd0);
      chk("idle_cnt",   32'(plot_count), 32'd0);
      chk("idle_busy",  32'(busy),       32'd0);
      chk("idle_gnt",   32'(gnt),        32'd0);
      step();
    end

    // Round-robin with all three requesting
    for (int i = 0; i < NREQ; i++) set_px(i, 8'(20*i + 1), 7'(i + 1), 3'(i + 1));
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_gnt", 32'(gnt), 32'(rr_seq[k]));
      if (k > 0) chk("rr_plot", 32'(vga_plot), 32'd1);
      step();
    end
    req = '0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("rr_count", 32'(plot_count), 32'd6);
    chk("rr_plot_end", 32'(vga_plot), 32'd0);

    // Locked burst: requester 1 keeps the port for 4 pixels
    req = 3'b001; step();
    req = 3'b011; req_lock = 3'b010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lock_gnt", 32'(gnt), 32'b010);
      step();
    end
    req = 3'b001; req_lock = '0;
    @(negedge clk);
    chk("lock_rel_gnt", 32'(gnt), 32'b001);
    step();
    req = '0;
    @(negedge clk);
    chk("lock_rel_busy", 32'(busy), 32'd0);
    step();

    // Stalled burst resumes; then owner drops while requester 0 waits
    req = 3'b010; req_lock = 3'b010; step();
    req = '0;
    repeat (2) begin
      @(negedge clk);
      chk("stall_busy", 32'(busy), 32'd1);
      step();
    end
    req = 3'b011;
    @(negedge clk);
    chk("resume_gnt", 32'(gnt), 32'b010);
    step();
    req = 3'b001; req_lock = '0;
    repeat (2) begin
      @(negedge clk);
      chk("steal_gnt", 32'(gnt), 32'b001);
      step();
    end
    req = '0;
    @(negedge clk);
    chk("steal_busy", 32'(busy), 32'd0);
    step();

    // Data path: requester 2 alone at the last visible pixel
    set_px(2, 8'd159, 7'd119, 3'b101);
    req = 3'b100; step();
    req = '0;
    @(negedge clk);
    chk("dp_x",    32'(vga_x),      32'd159);
    chk("dp_y",    32'(vga_y),      32'd119);
    chk("dp_c",    32'(vga_colour), 32'd5);
    chk("dp_plot", 32'(vga_plot),   32'd1);
    step();
    @(negedge clk);
    chk("dp_plot_once", 32'(vga_plot), 32'd0);

    // Clip behaviour, counters cleared first
    count_clr = 1'b1; step(); count_clr = 1'b0;
    set_px(0, 8'd160, 7'd10, 3'd2);
    req = 3'b001;
    @(negedge clk);
    chk("clip_gnt", 32'(gnt), 32'b001);
    step();
    req = '0;
    @(negedge clk);
`ifdef PLOT_CLIP_EN
    chk("clip_plot", 32'(vga_plot),   32'd0);
    chk("clip_cnt",  32'(clip_count), 32'd1);
`else
    chk("noclip_plot", 32'(vga_plot), 32'd1);
    chk("noclip_x",    32'(vga_x),    32'd160);
`endif
    step();
    @(negedge clk);
`ifdef PLOT_CLIP_EN
    chk("clip_pcount", 32'(plot_count), 32'd0);
`else
    chk("noclip_pcount", 32'(plot_count), 32'd1);
`endif

    // Reset in the middle of a locked burst
    set_px(1, 8'd77, 7'd33, 3'd6);
    req = 3'b010; req_lock = 3'b010; step(); step();
    req = '0; req_lock = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_plot", 32'(vga_plot),   32'd0);
    chk("mrst_x",    32'(vga_x),      32'd0);
    chk("mrst_cnt",  32'(plot_count), 32'd0);
    chk("mrst_busy", 32'(busy),       32'd0);
    chk("mrst_gnt",  32'(gnt),        32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    req = 3'b011;
    @(negedge clk);
    chk("mrst_lock_gone", 32'(gnt), 32'b001);
    step();
    req = '0;
    step();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      req        = NREQ'($urandom);
      req_lock   = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_px(i, 8'($urandom_range(0, 200)), 7'($urandom_range(0, 127)), 3'($urandom));
      count_clr  = ($urandom_range(0, 63) == 0);
      step();
    end
    req = '0; req_lock = '0; count_clr = 1'b0;
    step(); step();

    // Saturation of plot_count, then clear against a simultaneous plot
    count_clr = 1'b1; step(); count_clr = 1'b0;
    set_px(0, 8'd5, 7'd5, 3'd1);
    req = 3'b001;
    repeat (65540) step();
    @(negedge clk);
    chk("sat_count", 32'(plot_count), 32'hFFFF);
    chk("sat_plot",  32'(vga_plot),   32'd1);
    step();
    count_clr = 1'b1; step(); count_clr = 1'b0;
    @(negedge clk);
    chk("clr_over_plot", 32'(plot_count), 32'd0);
    req = '0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
